tx_data_sched: RTL and testbench

Scheduler for the SpaceWire transmit FSM datapath. It drains an upstream show-ahead FIFO into the two TX character slots (slot A drives tx_data_in, slot B drives tx_data_in_0) in ping-pong order. It gates slot loading on available flow-control credit and owns the time-code request latch (tx_tcode_in/tcode_rdy_trnsp). It sits between the transport-layer FIFO/time-code source and the TX FSM, and observes state_tx to learn when a slot has been transmitted.

---
 rtl/spw_tx_pkg.sv | 45 ++++
 rtl/tx_tcode_latch.sv | 53 +++++
 rtl/tx_data_sched.sv | 128 ++++++++++++
 tb/tb_tx_data_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spw_tx_pkg.sv
// +-----------------------------------------------------------------+
// | Module  : spw_tx_pkg                                            |
// | Desc    : Shared SpaceWire TX encodings, char codes and helpers |
// | Rev     : 1.0  initial release                                  |
// +-----------------------------------------------------------------+
`default_nettype none

package spw_tx_pkg;

  localparam int DATA_W = 9;

  localparam logic [6:0] tx_spw_start       = 7'h00;
  localparam logic [6:0] tx_spw_null        = 7'h01;
  localparam logic [6:0] tx_spw_fct         = 7'h02;
  localparam logic [6:0] tx_spw_null_c      = 7'h04;
  localparam logic [6:0] tx_spw_fct_c       = 7'h08;
  localparam logic [6:0] tx_spw_data_c      = 7'h10;
  localparam logic [6:0] tx_spw_data_c_0    = 7'h20;
  localparam logic [6:0] tx_spw_time_code_c = 7'h40;

  typedef enum logic [2:0] {
    LT_NULL  = 3'd0,
    LT_FCT   = 3'd1,
    LT_EOP   = 3'd2,
    LT_EEP   = 3'd3,
    LT_DATA  = 3'd4,
    LT_TIMEC = 3'd5
  } last_type_e;

  localparam logic [DATA_W-1:0] EOP_CODE = 9'h100;
  localparam logic [DATA_W-1:0] EEP_CODE = 9'h101;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Startup/NULL/FCT exchange states mean the link is not yet carrying traffic.
  function automatic logic link_running(input logic [6:0] st);
    return !((st == tx_spw_start) || (st == tx_spw_null) || (st == tx_spw_fct));
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_tcode_latch.sv
// +-----------------------------------------------------------------+
// | Module  : tx_tcode_latch                                        |
// | Desc    : Time-code request latch with pending and overrun flag |
// | Rev     : 1.0  initial release                                  |
// +-----------------------------------------------------------------+
`default_nettype none

module tx_tcode_latch (
  input  logic       pclk_tx,
  input  logic       enable_tx,
  input  logic       i_link_running,
  input  logic       i_link_drop,
  input  logic       i_tc_req,
  input  logic [7:0] i_tc_value,
  input  logic       i_tc_done,
  output logic [7:0] o_tcode,
  output logic       o_tc_pending,
  output logic       o_tc_overrun
);

  logic [7:0] r_tcode;
  logic       r_pending;
  logic       r_overrun;
  logic       w_accept;

  // A request landing on the same edge as the clear replaces the finished code.
  assign w_accept = i_link_running & i_tc_req & (~r_pending | i_tc_done);

  always_ff @(posedge pclk_tx) begin
    if (!enable_tx) begin
      r_tcode   <= 8'h00;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_link_running & i_tc_req & r_pending & ~i_tc_done & ~i_link_drop;
      if (i_link_drop) begin
        r_pending <= 1'b0;
      end else if (w_accept) begin
        r_tcode   <= i_tc_value;
        r_pending <= 1'b1;
      end else if (i_tc_done) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_tcode      = r_tcode;
  assign o_tc_pending = r_pending;
  assign o_tc_overrun = r_overrun;

endmodule

`default_nettype wire

// File: rtl/tx_data_sched.sv
// +-----------------------------------------------------------------+
// | Module  : tx_data_sched                                         |
// | Desc    : Ping-pong FIFO-to-TX-slot scheduler with credit gating|
// | Rev     : 1.0  initial release                                  |
// +-----------------------------------------------------------------+
`default_nettype none

module tx_data_sched #(
  parameter int DATA_W   = spw_tx_pkg::DATA_W,
  parameter int CREDIT_W = 6
) (
  input  logic                pclk_tx,
  input  logic                enable_tx,
  input  logic                fifo_empty,
  input  logic [DATA_W-1:0]   fifo_rdata,
  output logic                fifo_rd_en,
  input  logic [CREDIT_W-1:0] fct_counter_p,
  input  logic [6:0]          state_tx,
  input  logic                tc_req,
  input  logic [7:0]          tc_value,
  input  logic                ready_tx_timecode,
  output logic [DATA_W-1:0]   tx_data_in,
  output logic [DATA_W-1:0]   tx_data_in_0,
  output logic                process_data,
  output logic                process_data_0,
  output logic [7:0]          tx_tcode_in,
  output logic                tcode_rdy_trnsp,
  output logic                tc_overrun,
  output logic                flush
);

  import spw_tx_pkg::*;

  logic [6:0]          r_prev_state;
  slot_state_e         r_slot_a;
  slot_state_e         r_slot_b;
  logic [DATA_W-1:0]   r_data_a;
  logic [DATA_W-1:0]   r_data_b;
  logic                r_ptr_b;
  logic                r_flush;

  logic                w_running;
  logic                w_release_a;
  logic                w_release_b;
  logic                w_sel_empty;
  logic                w_sel_busy;
  logic                w_load;
  logic                w_drop;
  logic                w_tc_pending;
  logic [CREDIT_W-1:0] w_outstanding;

  assign w_running   = link_running(state_tx);
  assign w_release_a = (r_prev_state == tx_spw_data_c)   && (state_tx != tx_spw_data_c);
  assign w_release_b = (r_prev_state == tx_spw_data_c_0) && (state_tx != tx_spw_data_c_0);

  // Every FULL slot is assumed to still owe a credit, even if partly sent.
  assign w_outstanding = CREDIT_W'(r_slot_a == SLOT_FULL) + CREDIT_W'(r_slot_b == SLOT_FULL);

  assign w_sel_empty = r_ptr_b ? (r_slot_b == SLOT_EMPTY) : (r_slot_a == SLOT_EMPTY);
  assign w_sel_busy  = (state_tx == (r_ptr_b ? tx_spw_data_c_0 : tx_spw_data_c));

  assign w_load = enable_tx & w_running & ~fifo_empty & w_sel_empty & ~w_sel_busy
                & (fct_counter_p > w_outstanding);

  assign w_drop = (state_tx == tx_spw_start)
                & ((r_slot_a == SLOT_FULL) | (r_slot_b == SLOT_FULL) | w_tc_pending);

  always_ff @(posedge pclk_tx) begin
    if (!enable_tx) begin
      r_prev_state <= tx_spw_start;
      r_slot_a     <= SLOT_EMPTY;
      r_slot_b     <= SLOT_EMPTY;
      r_data_a     <= '0;
      r_data_b     <= '0;
      r_ptr_b      <= 1'b0;
      r_flush      <= 1'b0;
    end else begin
      r_prev_state <= state_tx;
      r_flush      <= w_drop;
      if (w_drop) begin
        // Data registers are deliberately left holding their last characters.
        r_slot_a <= SLOT_EMPTY;
        r_slot_b <= SLOT_EMPTY;
        r_ptr_b  <= 1'b0;
      end else begin
        if (w_load && !r_ptr_b) begin
          r_data_a <= fifo_rdata;
          r_slot_a <= SLOT_FULL;
        end else if (w_release_a) begin
          r_slot_a <= SLOT_EMPTY;
        end
        if (w_load && r_ptr_b) begin
          r_data_b <= fifo_rdata;
          r_slot_b <= SLOT_FULL;
        end else if (w_release_b) begin
          r_slot_b <= SLOT_EMPTY;
        end
        if (w_load) begin
          r_ptr_b <= ~r_ptr_b;
        end
      end
    end
  end

  tx_tcode_latch u_tcode (
    .pclk_tx        (pclk_tx),
    .enable_tx      (enable_tx),
    .i_link_running (w_running),
    .i_link_drop    (w_drop),
    .i_tc_req       (tc_req),
    .i_tc_value     (tc_value),
    .i_tc_done      (ready_tx_timecode),
    .o_tcode        (tx_tcode_in),
    .o_tc_pending   (w_tc_pending),
    .o_tc_overrun   (tc_overrun)
  );

  assign fifo_rd_en      = w_load;
  assign tx_data_in      = r_data_a;
  assign tx_data_in_0    = r_data_b;
  assign process_data    = (r_slot_a == SLOT_FULL);
  assign process_data_0  = (r_slot_b == SLOT_FULL);
  assign tcode_rdy_trnsp = w_tc_pending;
  assign flush           = r_flush;

endmodule

`default_nettype wire

// File: tb/tb_tx_data_sched.sv
// +-----------------------------------------------------------------+
// | Module  : tb_tx_data_sched                                      |
// | Desc    : Directed bench with a reference model for the scheduler|
// | Rev     : 1.0  initial release                                  |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_tx_data_sched;

  localparam logic [6:0] ST_START  = 7'h00;
  localparam logic [6:0] ST_NULL   = 7'h01;
  localparam logic [6:0] ST_NULL_C = 7'h04;
  localparam logic [6:0] ST_DATA_C = 7'h10;
  localparam logic [6:0] ST_DATA_0 = 7'h20;

  logic       clk;
  logic       en;
  logic       fifo_empty;
  logic [8:0] fifo_rdata;
  logic       rd_en;
  logic [5:0] credit;
  logic [6:0] st;
  logic       tc_req;
  logic [7:0] tc_val;
  logic       tc_done;
  logic [8:0] data_a;
  logic [8:0] data_b;
  logic       pd_a;
  logic       pd_b;
  logic [7:0] tcode;
  logic       tc_rdy;
  logic       tc_ovr;
  logic       flush;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] fq[$];

  // Reference state: slots as arrays, a fill index and the time-code latch.
  bit         m_valid = 0;
  bit         m_full[2];
  logic [8:0] m_data[2];
  int         m_ptr;
  logic [6:0] m_prev;
  logic [7:0] m_tcode;
  bit         m_rdy;
  bit         m_ovr;
  bit         m_flush;

  tx_data_sched dut (
    .pclk_tx           (clk),
    .enable_tx         (en),
    .fifo_empty        (fifo_empty),
    .fifo_rdata        (fifo_rdata),
    .fifo_rd_en        (rd_en),
    .fct_counter_p     (credit),
    .state_tx          (st),
    .tc_req            (tc_req),
    .tc_value          (tc_val),
    .ready_tx_timecode (tc_done),
    .tx_data_in        (data_a),
    .tx_data_in_0      (data_b),
    .process_data      (pd_a),
    .process_data_0    (pd_b),
    .tx_tcode_in       (tcode),
    .tcode_rdy_trnsp   (tc_rdy),
    .tc_overrun        (tc_ovr),
    .flush             (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_running(input logic [6:0] s);
    return !(s == ST_START || s == ST_NULL || s == 7'h02);
  endfunction

  // Model: FIFO pins refreshed after negedge, outputs compared, state advanced at posedge.
  initial begin
    bit e_rd;
    int nfull;
    bit run;
    bit drop;
    bit rel[2];
    forever begin
      @(negedge clk);
      #1;
      fifo_empty = (fq.size() == 0);
      fifo_rdata = (fq.size() == 0) ? 9'h000 : fq[0];
      #1;
      nfull = int'(m_full[0]) + int'(m_full[1]);
      run   = is_running(st);
      e_rd  = m_valid && en && run && (fq.size() > 0) && !m_full[m_ptr]
              && (st != (m_ptr == 1 ? ST_DATA_0 : ST_DATA_C)) && (int'(credit) > nfull);
      if (m_valid) begin
        chk("m_fifo_rd_en", {31'd0, rd_en}, {31'd0, e_rd});
        chk("m_tx_data_in", {23'd0, data_a}, {23'd0, m_data[0]});
        chk("m_tx_data_in_0", {23'd0, data_b}, {23'd0, m_data[1]});
        chk("m_process_data", {31'd0, pd_a}, {31'd0, m_full[0]});
        chk("m_process_data_0", {31'd0, pd_b}, {31'd0, m_full[1]});
        chk("m_tx_tcode_in", {24'd0, tcode}, {24'd0, m_tcode});
        chk("m_tcode_rdy", {31'd0, tc_rdy}, {31'd0, m_rdy});
        chk("m_tc_overrun", {31'd0, tc_ovr}, {31'd0, m_ovr});
        chk("m_flush", {31'd0, flush}, {31'd0, m_flush});
      end
      @(posedge clk);
      if (!en) begin
        m_valid = 1;
        m_full[0] = 0; m_full[1] = 0;
        m_data[0] = '0; m_data[1] = '0;
        m_ptr = 0; m_prev = ST_START;
        m_tcode = '0; m_rdy = 0; m_ovr = 0; m_flush = 0;
      end else if (m_valid) begin
        drop   = (st == ST_START) && (m_full[0] || m_full[1] || m_rdy);
        rel[0] = (m_prev == ST_DATA_C) && (st != ST_DATA_C);
        rel[1] = (m_prev == ST_DATA_0) && (st != ST_DATA_0);
        m_flush = drop;
        m_ovr   = run && tc_req && m_rdy && !tc_done && !drop;
        if (drop) begin
          m_full[0] = 0; m_full[1] = 0; m_ptr = 0; m_rdy = 0;
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (e_rd && m_ptr == i) begin
              m_data[i] = fq[0];
              m_full[i] = 1;
            end else if (rel[i]) begin
              m_full[i] = 0;
            end
          end
          if (e_rd) m_ptr = 1 - m_ptr;
          if (run && tc_req && (!m_rdy || tc_done)) begin
            m_tcode = tc_val;
            m_rdy   = 1;
          end else if (tc_done) begin
            m_rdy = 0;
          end
        end
        m_prev = st;
      end
      if (e_rd && fq.size() > 0) void'(fq.pop_front());
    end
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Directed stimulus; inputs change right after negedge, literal checks at +3.
  initial begin
    en = 1'b0; st = ST_NULL; credit = '0;
    tc_req = 1'b0; tc_val = '0; tc_done = 1'b0;
    fifo_empty = 1'b1; fifo_rdata = '0;
    repeat (3) next_cycle();
    #3;
    chk("rst_process_data", {31'd0, pd_a}, 32'd0);
    chk("rst_process_data_0", {31'd0, pd_b}, 32'd0);
    chk("rst_tx_data_in", {23'd0, data_a}, 32'd0);
    chk("rst_tcode_rdy", {31'd0, tc_rdy}, 32'd0);
    chk("rst_fifo_rd_en", {31'd0, rd_en}, 32'd0);

    // Ping-pong fill from a three-word FIFO with ample credit
    next_cycle(); en = 1'b1; st = ST_NULL_C; credit = 6'd7;
    fq.push_back(9'h041); fq.push_back(9'h042); fq.push_back(9'h100);
    #3 chk("t1_pop0", {31'd0, rd_en}, 32'd1);
    next_cycle(); #3 chk("t1_pop1", {31'd0, rd_en}, 32'd1);
    next_cycle(); #3;
    chk("t1_slot_a", {23'd0, data_a}, 32'h041);
    chk("t1_slot_b", {23'd0, data_b}, 32'h042);
    chk("t1_full_a", {31'd0, pd_a}, 32'd1);
    chk("t1_full_b", {31'd0, pd_b}, 32'd1);
    chk("t1_no_pop", {31'd0, rd_en}, 32'd0);

    // Slot A transmitted over five DATA_C cycles, released on exit
    next_cycle(); st = ST_DATA_C; #3 chk("t3_hold", {31'd0, rd_en}, 32'd0);
    repeat (4) begin next_cycle(); #3 chk("t3_hold", {31'd0, rd_en}, 32'd0); end
    next_cycle(); st = ST_NULL_C; #3;
    chk("t3_exit_no_pop", {31'd0, rd_en}, 32'd0);
    chk("t3_exit_full", {31'd0, pd_a}, 32'd1);
    next_cycle(); #3 chk("t3_third_pop", {31'd0, rd_en}, 32'd1);
    next_cycle(); #3;
    chk("t3_reload_a", {23'd0, data_a}, 32'h100);
    chk("t3_reload_full", {31'd0, pd_a}, 32'd1);

    // Time-code load, overrun, clear
    next_cycle(); tc_req = 1'b1; tc_val = 8'h85;
    next_cycle(); tc_req = 1'b0; #3;
    chk("tc_value", {24'd0, tcode}, 32'h85);
    chk("tc_pending", {31'd0, tc_rdy}, 32'd1);
    next_cycle(); tc_req = 1'b1; tc_val = 8'h86;
    next_cycle(); tc_req = 1'b0; #3;
    chk("tc_overrun", {31'd0, tc_ovr}, 32'd1);
    chk("tc_kept", {24'd0, tcode}, 32'h85);
    next_cycle(); tc_done = 1'b1; #3 chk("tc_ovr_pulse", {31'd0, tc_ovr}, 32'd0);
    next_cycle(); tc_done = 1'b0; #3 chk("tc_cleared", {31'd0, tc_rdy}, 32'd0);

    // Request coinciding with the clear
    next_cycle(); tc_req = 1'b1; tc_val = 8'h85;
    next_cycle(); tc_val = 8'h07; tc_done = 1'b1; #3 chk("tc2_pending", {31'd0, tc_rdy}, 32'd1);
    next_cycle(); tc_req = 1'b0; tc_done = 1'b0; #3;
    chk("tc2_value", {24'd0, tcode}, 32'h07);
    chk("tc2_still_pending", {31'd0, tc_rdy}, 32'd1);

    // Link drop with both slots full, then a one-cycle reset
    next_cycle(); st = ST_START;
    next_cycle(); #3;
    chk("drop_flush", {31'd0, flush}, 32'd1);
    chk("drop_pd_a", {31'd0, pd_a}, 32'd0);
    chk("drop_pd_b", {31'd0, pd_b}, 32'd0);
    chk("drop_tc", {31'd0, tc_rdy}, 32'd0);
    chk("drop_data_kept", {23'd0, data_a}, 32'h100);
    next_cycle(); en = 1'b0; #3;
    chk("drop_flush_pulse", {31'd0, flush}, 32'd0);
    chk("rst_rd_en_low", {31'd0, rd_en}, 32'd0);
    next_cycle(); en = 1'b1; #3;
    chk("rst2_data_a", {23'd0, data_a}, 32'd0);
    chk("rst2_data_b", {23'd0, data_b}, 32'd0);
    chk("rst2_tcode", {24'd0, tcode}, 32'd0);
    chk("rst2_flush", {31'd0, flush}, 32'd0);

    // Empty slot A is not loaded while DATA_C is current
    next_cycle(); st = ST_DATA_C; fq.push_back(9'h0AA); fq.push_back(9'h0BB);
    #3 chk("busy_no_pop", {31'd0, rd_en}, 32'd0);
    repeat (2) begin next_cycle(); #3 chk("busy_no_pop", {31'd0, rd_en}, 32'd0); end
    next_cycle(); st = ST_NULL_C; #3 chk("busy_exit_pop", {31'd0, rd_en}, 32'd1);
    next_cycle(); #3 chk("busy_pop_b", {31'd0, rd_en}, 32'd1);
    next_cycle(); #3;
    chk("busy_data_a", {23'd0, data_a}, 32'h0AA);
    chk("busy_data_b", {23'd0, data_b}, 32'h0BB);

    // Slot B release via DATA_C_0
    next_cycle(); st = ST_DATA_0;
    repeat (2) next_cycle();
    next_cycle(); st = ST_NULL_C;
    next_cycle(); #3;
    chk("relb_pd_b", {31'd0, pd_b}, 32'd0);
    chk("relb_pd_a", {31'd0, pd_a}, 32'd1);

    // Credit of one only fills slot A
    next_cycle(); st = ST_START;
    next_cycle(); st = ST_NULL_C; credit = 6'd1; fq.push_back(9'h101); fq.push_back(9'h055);
    #3 chk("cr1_pop", {31'd0, rd_en}, 32'd1);
    next_cycle(); #3 chk("cr1_blocked", {31'd0, rd_en}, 32'd0);
    repeat (2) begin next_cycle(); #3 chk("cr1_b_empty", {31'd0, pd_b}, 32'd0); end
    next_cycle(); credit = 6'd2; #3 chk("cr2_pop", {31'd0, rd_en}, 32'd1);
    next_cycle(); #3;
    chk("cr2_data_b", {23'd0, data_b}, 32'h055);
    chk("cr2_full_b", {31'd0, pd_b}, 32'd1);
    chk("cr1_eep_a", {23'd0, data_a}, 32'h101);

    // Time-code requests while the link is down are ignored
    next_cycle(); st = ST_START;
    next_cycle(); tc_req = 1'b1; tc_val = 8'h33;
    next_cycle(); tc_req = 1'b0; #3;
    chk("down_tc_rdy", {31'd0, tc_rdy}, 32'd0);
    chk("down_tc_ovr", {31'd0, tc_ovr}, 32'd0);
    chk("down_tc_val", {24'd0, tcode}, 32'd0);
    next_cycle(); st = ST_NULL; tc_req = 1'b1; tc_val = 8'h44;
    next_cycle(); tc_req = 1'b0; #3 chk("null_tc_rdy", {31'd0, tc_rdy}, 32'd0);

    repeat (3) next_cycle();
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
